bit_scan_encoder: RTL and testbench
===================================

// Module: bit_scan_encoder
// PURPOSE
//  Priority encoder, the inverse of the casez/casex first-match decoders in this codebase.
//  - A decoder maps a pattern to a match; this block maps a request vector to bit indices.
//  - Accepts one WIDTH-bit vector per valid/ready handshake.
//  - Emits the index of every set bit, one per output beat, in priority order (bit 0 first).
//  - Used wherever a multi-hot request word must be serialised into per-request indices.
// PARAMETERS
//  WIDTH  8                 request vector width, >= 2
//  IDX_W  $clog2(WIDTH)     index width (localparam, derived from WIDTH)
// PORTS
//  clk        in   1      single clock, all state on posedge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      in_vector valid
//  in_ready   out  1      block can accept a vector
//  in_vector  in   WIDTH  multi-hot request word
//  out_valid  out  1      out_index/out_last/out_empty valid
//  out_ready  in   1      sink accepts current beat
//  out_index  out  IDX_W  index of current set bit
//  out_last   out  1      final beat for this vector
//  out_empty  out  1      vector was all-zero (single beat, index 0)
// BEHAVIOUR
//  - Reset (sampled high at posedge):
//    - state=IDLE, pending=0.
//    - out_valid=0, out_index=0, out_last=0, out_empty=0.
//    - in_ready=0 while reset is high; 1 on the first cycle after release.
//  - State machine, 2 states: IDLE, SCAN.
//  - Input handshake:
//    - in_ready = (state==IDLE) && !reset.
//    - Accept = in_valid && in_ready.
//    - in_valid is ignored while in_ready=0; there is no queueing.
//  - IDLE + accept:
//    - pending <= in_vector; state <= SCAN.
//    - out_valid is 1 on the next cycle (latency 1).
//  - SCAN outputs, combinational from pending:
//    - out_index = lowest set bit of pending.
//    - out_last = pending has exactly one bit set, or pending==0.
//    - out_empty = (pending==0).
//    - out_valid = 1.
//  - Output fire = out_valid && out_ready:
//    - Clear the bit at out_index in pending.
//    - If out_last: state <= IDLE. in_ready=1 the cycle after the last fire,
//      giving one bubble between vectors.
//  - Zero vector: exactly one beat, out_index=0, out_empty=1, out_last=1.
//  - Backpressure: while out_valid && !out_ready, all out_* stay stable and pending is unchanged.
//  - Beats per vector = popcount(in_vector), or 1 if the vector is zero.
//    - Indices are strictly increasing within a vector.
//  - Reset mid-SCAN: remaining beats are discarded with no out_last; state returns to IDLE.
//  - X/Z on in_vector is not resolved; the bench drives only 0/1.
// TESTING
//  T1 in_vector=8'b1010_0100, out_ready=1 -> indices 2,5,7 on 3 consecutive cycles; out_last only with 7.
//  T2 in_vector=8'h00 -> one beat: index=0, out_empty=1, out_last=1; in_ready=1 on the next cycle.
//  T3 in_vector=8'h81, out_ready low for 3 cycles -> index 0 held stable 3 cycles, then 0,7 on release.
//  T4 in_vector=8'hFF, out_ready=1 -> indices 0..7 in 8 cycles; in_ready=1 on the 9th cycle after accept.
//  T5 in_valid held high in SCAN with a new vector 8'h10 -> ignored until IDLE, then emits index 4.
//  T6 reset pulse after beat 1 of 8'h0E -> out_valid=0 next cycle, no index 2/3 beats, in_ready=1 after release.

Source files
------------

// File: rtl/bit_scan_encoder.sv
// bit_scan_encoder: serialises a multi-hot request word into the indices of its
// set bits, lowest index first, one beat per valid/ready handshake on the output.
// An all-zero word produces a single beat flagged as empty.
module bit_scan_encoder #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_empty
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] w_pending_nxt;
  logic [WIDTH-1:0] w_pending_drop;
  logic [IDX_W-1:0] w_low_idx;
  logic             w_accept;
  logic             w_fire;
  logic             w_last;

  // State and pending-word registers; reset abandons any vector in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Lowest set bit of the pending word; scanning downward lets the lowest win.
  always_comb begin
    w_low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_pending[i]) w_low_idx = IDX_W'(i);
    end
  end

  // Next-state, pending update and handshake/output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_index      = '0;
    out_last       = 1'b0;
    out_empty      = 1'b0;
    w_accept       = 1'b0;
    w_fire         = 1'b0;
    // x & (x-1) clears the lowest set bit; zero result means at most one bit was set.
    w_pending_drop = r_pending & (r_pending - WIDTH'(1));
    w_last         = (w_pending_drop == '0);

    case (r_state)
      S_IDLE: begin
        in_ready = !reset;
        w_accept = in_valid && !reset;
        if (w_accept) begin
          w_pending_nxt = in_vector;
          w_state_nxt   = S_SCAN;
        end
      end
      S_SCAN: begin
        out_valid = 1'b1;
        out_index = w_low_idx;
        out_last  = w_last;
        out_empty = (r_pending == '0);
        w_fire    = out_ready;
        if (w_fire) begin
          w_pending_nxt = w_pending_drop;
          if (w_last) w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Directed bench for bit_scan_encoder: hand-computed beat sequences for the
// multi-hot, zero, backpressure, full, ignored-input and mid-scan-reset cases.
module tb_bit_scan_encoder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = 3;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vector;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             out_empty;

  int total;
  int bad;

  bit_scan_encoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vector (in_vector),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .out_empty (out_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Check one output beat: valid, index, last, empty.
  task automatic beat(input string tag, input int idx, input bit last, input bit empty);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_idx"},   32'(out_index), 32'(idx));
    chk({tag, "_last"},  32'(out_last),  32'(last));
    chk({tag, "_empty"}, 32'(out_empty), 32'(empty));
  endtask

  // Present a vector, wait (bounded) for in_ready, and return one negedge after accept.
  task automatic send(input logic [WIDTH-1:0] vec);
    int n;
    n = 0;
    in_vector = vec;
    in_valid  = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      step();
      #1;
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_vector = '0;
    out_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_out_empty", 32'(out_empty), 32'd0);
    reset = 1'b0;
    step();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // T1: 1010_0100 -> 2,5,7
    out_ready = 1'b1;
    send(8'b1010_0100);
    chk("t1_in_ready_busy", 32'(in_ready), 32'd0);
    beat("t1_b0", 2, 1'b0, 1'b0);
    step();
    beat("t1_b1", 5, 1'b0, 1'b0);
    step();
    beat("t1_b2", 7, 1'b1, 1'b0);
    step();
    chk("t1_done_valid", 32'(out_valid), 32'd0);
    chk("t1_done_ready", 32'(in_ready),  32'd1);

    // T2: zero vector -> single empty beat
    send(8'h00);
    beat("t2_b0", 0, 1'b1, 1'b1);
    step();
    chk("t2_done_valid", 32'(out_valid), 32'd0);
    chk("t2_done_ready", 32'(in_ready),  32'd1);

    // T3: 0x81 with 3 cycles of backpressure
    out_ready = 1'b0;
    send(8'h81);
    beat("t3_hold0", 0, 1'b0, 1'b0);
    step();
    beat("t3_hold1", 0, 1'b0, 1'b0);
    step();
    beat("t3_hold2", 0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    beat("t3_b1", 7, 1'b1, 1'b0);
    step();
    chk("t3_done_valid", 32'(out_valid), 32'd0);

    // T4: 0xFF -> 0..7, in_ready on the 9th cycle after accept
    send(8'hFF);
    for (int i = 0; i < 8; i++) begin
      beat($sformatf("t4_b%0d", i), i, (i == 7), 1'b0);
      chk($sformatf("t4_busy%0d", i), 32'(in_ready), 32'd0);
      step();
    end
    chk("t4_ready9", 32'(in_ready),  32'd1);
    chk("t4_valid9", 32'(out_valid), 32'd0);

    // T5: in_valid held with a new vector during SCAN is ignored until IDLE
    out_ready = 1'b0;
    send(8'h02);
    in_valid  = 1'b1;
    in_vector = 8'h10;
    #1;
    beat("t5_first", 1, 1'b1, 1'b0);
    chk("t5_busy", 32'(in_ready), 32'd0);
    step();
    beat("t5_stall", 1, 1'b1, 1'b0);
    out_ready = 1'b1;
    step();
    chk("t5_gap_valid", 32'(out_valid), 32'd0);
    chk("t5_gap_ready", 32'(in_ready),  32'd1);
    step();
    in_valid = 1'b0;
    beat("t5_second", 4, 1'b1, 1'b0);
    step();
    chk("t5_done_valid", 32'(out_valid), 32'd0);

    // T6: reset after the first beat of 0x0E discards beats 2 and 3
    send(8'h0E);
    beat("t6_b0", 1, 1'b0, 1'b0);
    step();
    beat("t6_b1", 2, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    step();
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_last",  32'(out_last),  32'd0);
    reset = 1'b0;
    #1;
    chk("t6_rel_ready", 32'(in_ready), 32'd1);
    step();
    chk("t6_after_valid", 32'(out_valid), 32'd0);
    chk("t6_after_ready", 32'(in_ready),  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
